// File: rtl/display_timing_pkg.sv
// Shared constants and types for the 640x480@60 raster timing generator.
// The VGA_* constants are the defaults for display_timing's parameters. A
// smaller raster can be built by overriding those parameters.
package display_timing_pkg;

  // Coordinate width. It must hold every count from 0 to H_TOTAL-1 and
  // 0 to V_TOTAL-1.
  localparam int COORD_W = 10;

  // Horizontal timing, in pixel clocks.
  localparam int VGA_H_RES  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_H_TOTAL = VGA_H_RES + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing, in lines.
  localparam int VGA_V_RES  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam int VGA_V_TOTAL = VGA_V_RES + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync polarity. This value is the active level of a sync pulse.
  localparam bit SYNC_ACTIVE_LOW = 1'b0;

  // Compensation for the colour pipeline that follows this block.
  localparam int PIPE_DLY_DEF = 2;
  localparam int PIPE_DLY_MAX = 8;

  // Encoder-facing signals. They are bundled so that one shift register
  // can delay all of them together.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } vid_sync_t;

endpackage

// File: rtl/sync_delay.sv
// W-bit by N-stage shift register clocked by clk, with no enable.
// Every stage resets asynchronously to RST_VAL, so the output tap holds
// RST_VAL for the first N clocks after reset.
// N must be 1 or more. The parent module bypasses this block when it needs
// zero delay.
module sync_delay
  import display_timing_pkg::*;
#(
  parameter int           W       = 1,
  parameter int           N       = PIPE_DLY_DEF,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stages [N];

  // Shift din through N stages. Reset loads the idle value into every stage.
  // NOTE: this is a handful of flops, not a RAM. Resetting every entry is
  // cheap, and it is required so that the taps hold a defined level after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stages[i] <= RST_VAL;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < N; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[N-1];

endmodule

// File: rtl/display_timing.sv
// Raster timing generator for the 640x480@60 video path.
// The block produces the pixel coordinates sx/sy, the line and frame
// strobes for the game logic, and HSYNC/VSYNC/DE for the DVI encoder. It
// also produces copies of the sync and DE signals, delayed by PIPE_DLY
// clocks, to match the latency of the colour pipeline.
module display_timing
  import display_timing_pkg::*;
#(
  parameter int CORDW    = COORD_W,
  parameter int H_RES    = VGA_H_RES,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_RES    = VGA_V_RES,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = SYNC_ACTIVE_LOW,
  parameter bit V_POL    = SYNC_ACTIVE_LOW,
  parameter int PIPE_DLY = PIPE_DLY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line,
  output logic             frame,
  output logic             hsync_d,
  output logic             vsync_d,
  output logic             de_d
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // Decode thresholds at coordinate width. All comparisons below are
  // therefore CORDW bits wide.
  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC - 1);

  // Value of the delay taps while reset is asserted: both syncs idle, DE low.
  localparam vid_sync_t SYNC_RST = '{hsync: ~H_POL, vsync: ~V_POL, de: 1'b0};

  // Parameter legality checks, evaluated at elaboration.
  if (PIPE_DLY > PIPE_DLY_MAX) begin : g_chk_dly
    $error("display_timing: PIPE_DLY=%0d exceeds the maximum of %0d",
           PIPE_DLY, PIPE_DLY_MAX);
  end
  if (H_TOTAL >= (1 << CORDW) || V_TOTAL >= (1 << CORDW)) begin : g_chk_cordw
    $error("display_timing: totals %0dx%0d do not fit in CORDW=%0d",
           H_TOTAL, V_TOTAL, CORDW);
  end

  logic [CORDW-1:0] sx_next;
  logic [CORDW-1:0] sy_next;
  logic             de_next;
  logic             hsync_next;
  logic             vsync_next;
  logic             line_next;
  logic             frame_next;

  // Next raster position. sy advances only when sx wraps, so both counters
  // wrap on the same edge at the last pixel of the frame.
  // NOTE: a combinational block uses blocking '=' and assigns defaults
  // first, so that no path leaves an output unassigned and no latch is inferred.
  always_comb begin
    sx_next = sx + 1'b1;
    sy_next = sy;
    if (sx == H_LAST) begin
      sx_next = '0;
      sy_next = (sy == V_LAST) ? '0 : sy + 1'b1;
    end
  end

  // Decode the video signals from the next position. After the register
  // stage they describe the same pixel as the registered sx/sy.
  always_comb begin
    de_next    = (sx_next < H_ACT) && (sy_next < V_ACT);
    hsync_next = ((sx_next >= HS_START) && (sx_next <= HS_END)) ? H_POL : ~H_POL;
    vsync_next = ((sy_next >= VS_START) && (sy_next <= VS_END)) ? V_POL : ~V_POL;
    line_next  = (sx_next == '0);
    frame_next = (sx_next == '0) && (sy_next == V_ACT);
  end

  // Counter and output registers. Reset parks the counters on the last
  // pixel, so the first clock edge after reset produces the pixel at (0,0).
  // NOTE: sequential state is updated with non-blocking '<=' so that every
  // register samples the values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx    <= H_LAST;
      sy    <= V_LAST;
      de    <= 1'b0;
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      line  <= 1'b0;
      frame <= 1'b0;
    end else begin
      sx    <= sx_next;
      sy    <= sy_next;
      de    <= de_next;
      hsync <= hsync_next;
      vsync <= vsync_next;
      line  <= line_next;
      frame <= frame_next;
    end
  end

  vid_sync_t sync_now;
  vid_sync_t sync_dly;

  assign sync_now = '{hsync: hsync, vsync: vsync, de: de};

  // Pipeline compensation. With zero delay the taps are plain wires to the
  // undelayed outputs.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign sync_dly = sync_now;
  end else begin : g_dly
    sync_delay #(
      .W      ($bits(vid_sync_t)),
      .N      (PIPE_DLY),
      .RST_VAL(SYNC_RST)
    ) u_sync_delay (
      .clk (clk),
      .rst (rst),
      .din (sync_now),
      .dout(sync_dly)
    );
  end

  assign hsync_d = sync_dly.hsync;
  assign vsync_d = sync_dly.vsync;
  assign de_d    = sync_dly.de;

endmodule

// File: tb/tb_display_timing.sv
// Self-checking bench for display_timing. It drives three instances from
// one clock and one reset:
//   dut0: full 640x480 timing, active-low syncs, PIPE_DLY=2
//   dut1: 15x12 raster, H_POL=1, V_POL=0, PIPE_DLY=2
//   dut2: 15x12 raster, H_POL=0, V_POL=1, PIPE_DLY=0
// A raster model, indexed by position, pushes the expected undelayed outputs
// into a per-instance queue. Each expected delayed value is popped from that
// queue PIPE_DLY pushes later.
module tb_display_timing;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de;
    logic       hs;
    logic       vs;
    logic       line;
    logic       frame;
    logic       hs_d;
    logic       vs_d;
    logic       de_d;
  } obs_t;

  localparam int HRES [3] = '{640, 8, 8};
  localparam int HFP  [3] = '{16, 2, 2};
  localparam int HSW  [3] = '{96, 3, 3};
  localparam int HBP  [3] = '{48, 2, 2};
  localparam int VRES [3] = '{480, 6, 6};
  localparam int VFP  [3] = '{10, 1, 1};
  localparam int VSW  [3] = '{2, 2, 2};
  localparam int VBP  [3] = '{33, 3, 3};
  localparam bit HPOL [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit VPOL [3] = '{1'b0, 1'b0, 1'b1};
  localparam int DLY  [3] = '{2, 2, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  obs_t obs [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [9:0] sx, sy;
    logic de, hsync, vsync, line, frame, hsync_d, vsync_d, de_d;
    display_timing #(
      .CORDW(10), .H_RES(HRES[g]), .H_FP(HFP[g]), .H_SYNC(HSW[g]), .H_BP(HBP[g]),
      .V_RES(VRES[g]), .V_FP(VFP[g]), .V_SYNC(VSW[g]), .V_BP(VBP[g]),
      .H_POL(HPOL[g]), .V_POL(VPOL[g]), .PIPE_DLY(DLY[g])
    ) dut (
      .clk(clk), .rst(rst), .sx(sx), .sy(sy), .de(de), .hsync(hsync),
      .vsync(vsync), .line(line), .frame(frame), .hsync_d(hsync_d),
      .vsync_d(vsync_d), .de_d(de_d)
    );
    assign obs[g] = '{sx: sx, sy: sy, de: de, hs: hsync, vs: vsync, line: line,
                      frame: frame, hs_d: hsync_d, vs_d: vsync_d, de_d: de_d};
  end

  int n_checks = 0;
  int n_fail   = 0;
  int mx [3];
  int my [3];
  obs_t q0 [$];
  obs_t q1 [$];
  obs_t q2 [$];

  function automatic int htot(int i);
    return HRES[i] + HFP[i] + HSW[i] + HBP[i];
  endfunction

  function automatic int vtot(int i);
    return VRES[i] + VFP[i] + VSW[i] + VBP[i];
  endfunction

  // Expected undelayed outputs for raster position (x,y).
  function automatic obs_t model(int i, int x, int y);
    obs_t o;
    o       = '0;
    o.sx    = 10'(x);
    o.sy    = 10'(y);
    o.de    = (x < HRES[i]) && (y < VRES[i]);
    o.hs    = (x >= HRES[i] + HFP[i] && x < HRES[i] + HFP[i] + HSW[i]) ? HPOL[i] : !HPOL[i];
    o.vs    = (y >= VRES[i] + VFP[i] && y < VRES[i] + VFP[i] + VSW[i]) ? VPOL[i] : !VPOL[i];
    o.line  = (x == 0);
    o.frame = (x == 0) && (y == VRES[i]);
    return o;
  endfunction

  // Reset state: the last pixel with idle syncs, and taps at the same idle values.
  function automatic obs_t reset_exp(int i);
    obs_t o;
    o      = model(i, htot(i) - 1, vtot(i) - 1);
    o.line = 1'b0;
    o.hs_d = !HPOL[i];
    o.vs_d = !VPOL[i];
    o.de_d = 1'b0;
    return o;
  endfunction

  task automatic push_pop(input int i, input obs_t u, output obs_t d);
    case (i)
      0:       begin q0.push_back(u); d = q0.pop_front(); end
      1:       begin q1.push_back(u); d = q1.pop_front(); end
      default: begin q2.push_back(u); d = q2.pop_front(); end
    endcase
  endtask

  // Re-arm the model after reset and preload each delay queue with reset-state values.
  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      mx[i] = htot(i) - 1;
      my[i] = vtot(i) - 1;
      for (int k = 0; k < DLY[i]; k++) begin
        case (i)
          0:       q0.push_back(reset_exp(i));
          1:       q1.push_back(reset_exp(i));
          default: q2.push_back(reset_exp(i));
        endcase
      end
    end
  endtask

  // One clock: advance the model, score every instance, return at posedge+1.
  task automatic cycle();
    obs_t e [3];
    obs_t d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (mx[i] == htot(i) - 1) begin
        mx[i] = 0;
        my[i] = (my[i] == vtot(i) - 1) ? 0 : my[i] + 1;
      end else begin
        mx[i]++;
      end
      e[i] = model(i, mx[i], my[i]);
      push_pop(i, e[i], d);
      e[i].hs_d = d.hs;
      e[i].vs_d = d.vs;
      e[i].de_d = d.de;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs[i] !== e[i]) begin
        n_fail++;
        $display("FAIL scoreboard dut%0d: got sx=%0d sy=%0d flags=%b, expected sx=%0d sy=%0d flags=%b",
                 i, obs[i].sx, obs[i].sy, obs[i][7:0], e[i].sx, e[i].sy, e[i][7:0]);
      end
    end
  endtask

  task automatic test_reset();
    logic [26:0] got, want;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs[i] !== reset_exp(i)) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %h, expected %h", i, obs[i], reset_exp(i));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle();
    got  = {obs[0].sx, obs[0].sy, obs[0].de, obs[0].line, obs[0].hs, obs[0].vs,
            obs[0].frame, obs[0].de_d, obs[0].hs_d};
    want = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL first_edge dut0: got %b, expected %b", got, want);
    end
    n_checks++;
    if (obs[1].hs !== 1'b0 || obs[1].line !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge_hpol dut1: got hs=%b line=%b, expected hs=0 line=1",
               obs[1].hs, obs[1].line);
    end
  endtask

  task automatic test_line_wrap();
    int prev_sy;
    for (int k = 0; k < 1000 && obs[0].sx != 10'd799; k++) cycle();
    prev_sy = int'(obs[0].sy);
    cycle();
    n_checks++;
    if (obs[0].sx !== 10'd0 || int'(obs[0].sy) != prev_sy + 1) begin
      n_fail++;
      $display("FAIL line_wrap: got sx=%0d sy=%0d, expected sx=0 sy=%0d",
               obs[0].sx, obs[0].sy, prev_sy + 1);
    end
  endtask

  task automatic test_frame_wrap();
    for (int k = 0; k < 400 && !(obs[1].sx == 10'd14 && obs[1].sy == 10'd11); k++) cycle();
    n_checks++;
    if (!(obs[1].sx == 10'd14 && obs[1].sy == 10'd11)) begin
      n_fail++;
      $display("FAIL frame_wrap_wait: got sx=%0d sy=%0d, expected (14,11) within 400 clocks",
               obs[1].sx, obs[1].sy);
    end
    cycle();
    n_checks++;
    if (obs[1].sx !== 10'd0 || obs[1].sy !== 10'd0) begin
      n_fail++;
      $display("FAIL frame_wrap: got sx=%0d sy=%0d, expected sx=0 sy=0", obs[1].sx, obs[1].sy);
    end
  endtask

  task automatic test_hsync();
    int cnt, first;
    for (int k = 0; k < 1000 && obs[0].sx != 10'd0; k++) cycle();
    cnt = 0; first = -1;
    for (int k = 0; k < 800; k++) begin
      if (obs[0].hs === 1'b0) begin
        if (first < 0) first = int'(obs[0].sx);
        cnt++;
      end
      cycle();
    end
    n_checks++;
    if (cnt != 96 || first != 656) begin
      n_fail++;
      $display("FAIL hsync_width dut0: got %0d clocks from sx=%0d, expected 96 from sx=656",
               cnt, first);
    end
    for (int k = 0; k < 20 && obs[1].sx != 10'd0; k++) cycle();
    cnt = 0; first = -1;
    for (int k = 0; k < 15; k++) begin
      if (obs[1].hs === 1'b1) begin
        if (first < 0) first = int'(obs[1].sx);
        cnt++;
      end
      cycle();
    end
    n_checks++;
    if (cnt != 3 || first != 10) begin
      n_fail++;
      $display("FAIL hsync_active_high dut1: got %0d clocks from sx=%0d, expected 3 from sx=10",
               cnt, first);
    end
  endtask

  task automatic test_vsync();
    int cnt1, cnt2, first, bad;
    logic prev;
    for (int k = 0; k < 400 && !(obs[1].sx == 10'd0 && obs[1].sy == 10'd0); k++) cycle();
    cnt1 = 0; cnt2 = 0; first = -1; bad = 0; prev = obs[1].vs;
    for (int k = 0; k < 180; k++) begin
      if (obs[1].vs === 1'b0) begin
        if (first < 0) first = int'(obs[1].sy);
        cnt1++;
      end
      if (obs[2].vs === 1'b1) cnt2++;
      if (obs[1].vs !== prev && obs[1].sx != 10'd0) bad++;
      prev = obs[1].vs;
      cycle();
    end
    n_checks++;
    if (cnt1 != 30 || first != 7 || bad != 0) begin
      n_fail++;
      $display("FAIL vsync_low dut1: got %0d clocks from sy=%0d (%0d mid-line edges), expected 30 from sy=7 (0)",
               cnt1, first, bad);
    end
    n_checks++;
    if (cnt2 != 30) begin
      n_fail++;
      $display("FAIL vsync_high dut2: got %0d active clocks, expected 30", cnt2);
    end
  endtask

  task automatic test_frames();
    int frames, de_cnt, bad_pos, t0, t1;
    for (int k = 0; k < 400 && !(obs[1].sx == 10'd0 && obs[1].sy == 10'd0); k++) cycle();
    frames = 0; de_cnt = 0; bad_pos = 0; t0 = -1; t1 = -1;
    for (int k = 0; k < 360; k++) begin
      if (obs[1].de === 1'b1) de_cnt++;
      if (obs[1].frame === 1'b1) begin
        if (obs[1].sx != 10'd0 || obs[1].sy != 10'd6) bad_pos++;
        if (t0 < 0) t0 = k; else t1 = k;
        frames++;
      end
      cycle();
    end
    n_checks++;
    if (frames != 2 || bad_pos != 0 || t1 - t0 != 180) begin
      n_fail++;
      $display("FAIL frame_pulse dut1: got %0d pulses, %0d misplaced, spacing %0d; expected 2, 0, 180",
               frames, bad_pos, t1 - t0);
    end
    n_checks++;
    if (de_cnt != 96) begin
      n_fail++;
      $display("FAIL de_count dut1: got %0d over two frames, expected 96", de_cnt);
    end
  endtask

  task automatic test_delay();
    for (int k = 0; k < 1000 && obs[0].sx != 10'd640; k++) cycle();
    n_checks++;
    if (obs[0].de !== 1'b0 || obs[0].de_d !== 1'b1) begin
      n_fail++;
      $display("FAIL de_d_lag dut0: got de=%b de_d=%b at sx=640, expected de=0 de_d=1",
               obs[0].de, obs[0].de_d);
    end
    cycle(); cycle();
    n_checks++;
    if (obs[0].sx !== 10'd642 || obs[0].de_d !== 1'b0) begin
      n_fail++;
      $display("FAIL de_d_fall dut0: got sx=%0d de_d=%b, expected sx=642 de_d=0",
               obs[0].sx, obs[0].de_d);
    end
    for (int k = 0; k < 20 && obs[1].sx != 10'd10; k++) cycle();
    n_checks++;
    if (obs[1].hs !== 1'b1 || obs[1].hs_d !== 1'b0 || obs[2].hs_d !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_d_edge at sx=10: got dut1 hs=%b hs_d=%b dut2 hs_d=%b, expected 1 0 0",
               obs[1].hs, obs[1].hs_d, obs[2].hs_d);
    end
    cycle(); cycle();
    n_checks++;
    if (obs[1].hs_d !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_d_delayed dut1: got hs_d=%b at sx=%0d, expected 1 at sx=12",
               obs[1].hs_d, obs[1].sx);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 1000 && obs[0].sx != 10'd300; k++) cycle();
    #3 rst = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs[i] !== reset_exp(i)) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got %h, expected %h before next edge",
                 i, obs[i], reset_exp(i));
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle();
    n_checks++;
    if (obs[0].sx !== 10'd0 || obs[0].sy !== 10'd0 || obs[0].de !== 1'b1 || obs[0].line !== 1'b1) begin
      n_fail++;
      $display("FAIL restart dut0: got sx=%0d sy=%0d de=%b line=%b, expected 0 0 1 1",
               obs[0].sx, obs[0].sy, obs[0].de, obs[0].line);
    end
    repeat (20) cycle();
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_frame_wrap();
    test_hsync();
    test_vsync();
    test_frames();
    test_delay();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
